// File: rtl/echo_pipeline_sequencer.sv
// Per-sample sequencer for the echo-cancellation datapath: issues ordered enable
// pulses to the conversion, lag, output and cancellation stages once per sampling period.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | waiting for a frame start
// S_CONV_PULSE | enable_conv high for PULSE_CYCLES clocks
// S_CONV_WAIT  | minimum wait, then ready_conv check window
// S_LAG_PULSE  | enable_lag high for PULSE_CYCLES clocks
// S_LAG_WAIT   | minimum wait, then ready_lag check window
// S_OUT_PULSE  | enable_out high for PULSE_CYCLES clocks
// S_DONE       | one clock; frame counted
module echo_pipeline_sequencer #(
    parameter int PULSE_CYCLES          = 2,
    parameter int CONV_WAIT             = 8,
    parameter int LAG_WAIT              = 600,
    parameter int READY_TIMEOUT         = 64,
    parameter int SAMPLING_DELAY_FRAMES = 2,
    parameter int WARMUP_FRAMES         = 3
) (
    input  logic        clk_operation,
    input  logic        rst,
    input  logic        run,
    input  logic [12:0] sampling_cycle_counter,
    input  logic        ready_conv,
    input  logic        ready_lag,
    output logic        enable_conv,
    output logic        enable_lag,
    output logic        enable_out,
    output logic        enable_sampling,
    output logic        enable_cancel,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic        timeout_err,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_CONV_PULSE, S_CONV_WAIT, S_LAG_PULSE, S_LAG_WAIT, S_OUT_PULSE, S_DONE
    } state_t;

    localparam int TW = 16;
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] CONV_LOAD  = TW'(CONV_WAIT + READY_TIMEOUT - 1);
    localparam logic [TW-1:0] LAG_LOAD   = TW'(LAG_WAIT + READY_TIMEOUT - 1);
    // Timer at or below this value means the minimum wait has elapsed.
    localparam logic [TW-1:0] WINDOW     = TW'(READY_TIMEOUT);

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [12:0]   prev_cnt_q;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]    done_cnt_q, done_cnt_d;
    logic          timeout_err_q, timeout_err_d;
    logic          overrun_q, overrun_d;
    logic          en_conv_q, en_conv_d;
    logic          en_lag_q, en_lag_d;
    logic          en_out_q, en_out_d;
    logic          en_samp_q, en_samp_d;
    logic          en_canc_q, en_canc_d;
    logic          busy_q, busy_d;
    logic          frame_start, timeout_set, overrun_set, frame_done;

    assign frame_start = run && (sampling_cycle_counter == 13'd0) && (prev_cnt_q != 13'd0);

    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            prev_cnt_q    <= 13'h1FFF;
            frame_cnt_q   <= '0;
            done_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            en_conv_q     <= 1'b0;
            en_lag_q      <= 1'b0;
            en_out_q      <= 1'b0;
            en_samp_q     <= 1'b0;
            en_canc_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prev_cnt_q    <= sampling_cycle_counter;
            frame_cnt_q   <= frame_cnt_d;
            done_cnt_q    <= done_cnt_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
            en_conv_q     <= en_conv_d;
            en_lag_q      <= en_lag_d;
            en_out_q      <= en_out_d;
            en_samp_q     <= en_samp_d;
            en_canc_q     <= en_canc_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_set = 1'b0;
        overrun_set = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_CONV_PULSE;
                    cnt_d   = PULSE_LOAD;
                end
            end
            S_CONV_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_CONV_WAIT;
                    cnt_d   = CONV_LOAD;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            S_CONV_WAIT: begin
                if (cnt_q <= WINDOW && ready_conv) begin
                    state_d = S_LAG_PULSE;
                    cnt_d   = PULSE_LOAD;
                end else if (cnt_q == '0) begin
                    state_d     = S_IDLE;
                    timeout_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            S_LAG_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_LAG_WAIT;
                    cnt_d   = LAG_LOAD;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            S_LAG_WAIT: begin
                if (cnt_q <= WINDOW && ready_lag) begin
                    state_d = S_OUT_PULSE;
                    cnt_d   = PULSE_LOAD;
                end else if (cnt_q == '0) begin
                    state_d     = S_IDLE;
                    timeout_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            S_OUT_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                frame_done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // A new frame boundary while busy abandons the frame in flight.
        if (frame_start && state_q != S_IDLE) begin
            state_d     = S_CONV_PULSE;
            cnt_d       = PULSE_LOAD;
            overrun_set = 1'b1;
            frame_done  = 1'b0;
        end
    end

    always_comb begin
        en_conv_d     = (state_d == S_CONV_PULSE);
        en_lag_d      = (state_d == S_LAG_PULSE);
        en_out_d      = (state_d == S_OUT_PULSE);
        busy_d        = (state_d != S_IDLE);
        frame_cnt_d   = frame_cnt_q + 16'(frame_done);
        done_cnt_d    = (frame_done && done_cnt_q != 8'hFF) ? done_cnt_q + 8'd1 : done_cnt_q;
        timeout_err_d = timeout_err_q | timeout_set;
        overrun_d     = overrun_q | overrun_set;
        en_samp_d     = en_samp_q | (int'(done_cnt_q) >= SAMPLING_DELAY_FRAMES);
        en_canc_d     = en_canc_q | (int'(done_cnt_q) >= WARMUP_FRAMES);
    end

    assign enable_conv     = en_conv_q;
    assign enable_lag      = en_lag_q;
    assign enable_out      = en_out_q;
    assign enable_sampling = en_samp_q;
    assign enable_cancel   = en_canc_q;
    assign busy            = busy_q;
    assign frame_count     = frame_cnt_q;
    assign timeout_err     = timeout_err_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_echo_pipeline_sequencer.sv
// Directed bench for echo_pipeline_sequencer; expected values are hand-derived
// cycle positions relative to the sampling counter.
module tb_echo_pipeline_sequencer;

    logic        clk_operation = 1'b0;
    logic        rst;
    logic        run;
    logic [12:0] sampling_cycle_counter;
    logic        ready_conv;
    logic        ready_lag;
    logic        enable_conv, enable_lag, enable_out, enable_sampling, enable_cancel, busy;
    logic [15:0] frame_count;
    logic        timeout_err, overrun;

    echo_pipeline_sequencer dut (
        .clk_operation         (clk_operation),
        .rst                   (rst),
        .run                   (run),
        .sampling_cycle_counter(sampling_cycle_counter),
        .ready_conv            (ready_conv),
        .ready_lag             (ready_lag),
        .enable_conv           (enable_conv),
        .enable_lag            (enable_lag),
        .enable_out            (enable_out),
        .enable_sampling       (enable_sampling),
        .enable_cancel         (enable_cancel),
        .busy                  (busy),
        .frame_count           (frame_count),
        .timeout_err           (timeout_err),
        .overrun               (overrun)
    );

    always #5 clk_operation = ~clk_operation;

    int n_vec = 0;
    int n_err = 0;
    int period = 4000;
    bit hold = 1'b1;

    int n_conv, n_lag, n_out, conv_w, lag_w, out_w;
    int conv_rise_c, lag_rise_c, out_rise_c, te_rise_c, busy_fall_c;
    int excl_viol = 0;
    logic p_conv, p_lag, p_out, p_te, p_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_trk();
        n_conv = 0; n_lag = 0; n_out = 0;
        conv_w = 0; lag_w = 0; out_w = 0;
        conv_rise_c = -1; lag_rise_c = -1; out_rise_c = -1;
        te_rise_c = -1; busy_fall_c = -1;
    endtask

    // One clock: advance the sampling counter, then record what the DUT shows for it.
    task automatic step();
        @(posedge clk_operation);
        #1;
        if (!hold)
            sampling_cycle_counter = (int'(sampling_cycle_counter) >= period - 1) ? 13'd0
                                     : sampling_cycle_counter + 13'd1;
        if (enable_conv && !p_conv) begin n_conv++; conv_rise_c = int'(sampling_cycle_counter); end
        if (enable_lag && !p_lag)   begin n_lag++;  lag_rise_c  = int'(sampling_cycle_counter); end
        if (enable_out && !p_out)   begin n_out++;  out_rise_c  = int'(sampling_cycle_counter); end
        if (timeout_err && !p_te)   te_rise_c   = int'(sampling_cycle_counter);
        if (!busy && p_busy)        busy_fall_c = int'(sampling_cycle_counter);
        if (enable_conv) conv_w++;
        if (enable_lag)  lag_w++;
        if (enable_out)  out_w++;
        if (int'(enable_conv) + int'(enable_lag) + int'(enable_out) > 1) excl_viol++;
        p_conv = enable_conv; p_lag = enable_lag; p_out = enable_out;
        p_te = timeout_err; p_busy = busy;
    endtask

    task automatic run_until(input int target, input int max_cyc);
        int n = 0;
        do begin
            step();
            n++;
        end while (int'(sampling_cycle_counter) != target && n < max_cyc);
        if (int'(sampling_cycle_counter) != target)
            chk("wait_bound", 32'(sampling_cycle_counter), 32'(target));
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; ready_conv = 1'b1; ready_lag = 1'b1;
        sampling_cycle_counter = 13'd0;
        p_conv = 0; p_lag = 0; p_out = 0; p_te = 0; p_busy = 0;
        clr_trk();
        repeat (3) step();
        chk("reset_outputs", 32'({enable_conv, enable_lag, enable_out, enable_sampling, enable_cancel,
                                  busy, timeout_err, overrun, frame_count}), 32'd0);
        rst = 1'b0;
        hold = 1'b0;

        // Frame 1, nominal
        run_until(700, 800);
        chk("f1_conv_rise", 32'(conv_rise_c), 32'd1);
        chk("f1_conv_width", 32'(conv_w), 32'd2);
        chk("f1_lag_rise", 32'(lag_rise_c), 32'd11);
        chk("f1_lag_width", 32'(lag_w), 32'd2);
        chk("f1_out_rise", 32'(out_rise_c), 32'd613);
        chk("f1_out_width", 32'(out_w), 32'd2);
        chk("f1_busy_fall", 32'(busy_fall_c), 32'd616);
        chk("f1_frame_count", 32'(frame_count), 32'd1);
        chk("f1_sampling", 32'(enable_sampling), 32'd0);
        chk("f1_cancel", 32'(enable_cancel), 32'd0);

        run_until(700, 4100);
        chk("f2_frame_count", 32'(frame_count), 32'd2);
        chk("f2_sampling", 32'(enable_sampling), 32'd1);
        chk("f2_cancel", 32'(enable_cancel), 32'd0);
        run_until(700, 4100);
        chk("f3_frame_count", 32'(frame_count), 32'd3);
        chk("f3_cancel", 32'(enable_cancel), 32'd1);

        // ready_lag stuck low: timeout 600+64 clocks after lag pulse ends (counter 13)
        ready_lag = 1'b0;
        clr_trk();
        run_until(700, 4100);
        chk("to_lag_pulses", 32'(n_lag), 32'd1);
        chk("to_err_rise", 32'(te_rise_c), 32'd677);
        chk("to_busy_fall", 32'(busy_fall_c), 32'd677);
        chk("to_no_out", 32'(n_out), 32'd0);
        chk("to_frame_count", 32'(frame_count), 32'd3);
        ready_lag = 1'b1;
        clr_trk();
        run_until(700, 4100);
        chk("rec_out_rise", 32'(out_rise_c), 32'd613);
        chk("rec_frame_count", 32'(frame_count), 32'd4);
        chk("rec_err_sticky", 32'(timeout_err), 32'd1);

        // Short 300-clock period: every wrap restarts the frame
        period = 300;
        clr_trk();
        for (int i = 0; i < 900; i++) step();
        chk("ov_conv_pulses", 32'(n_conv), 32'd3);
        chk("ov_lag_pulses", 32'(n_lag), 32'd3);
        chk("ov_no_out", 32'(n_out), 32'd0);
        chk("ov_flag", 32'(overrun), 32'd1);
        chk("ov_frame_count", 32'(frame_count), 32'd4);
        period = 4000;
        clr_trk();
        run_until(1000, 1200);
        chk("ov_tail_out_rise", 32'(out_rise_c), 32'd613);
        chk("ov_tail_frame_count", 32'(frame_count), 32'd5);

        // Counter held at zero for 50 clocks
        clr_trk();
        sampling_cycle_counter = 13'd0;
        hold = 1'b1;
        for (int i = 0; i < 50; i++) step();
        hold = 1'b0;
        run_until(700, 800);
        chk("hold_conv_pulses", 32'(n_conv), 32'd1);
        chk("hold_frame_count", 32'(frame_count), 32'd6);

        // run dropped during LAG_WAIT
        clr_trk();
        run_until(100, 4100);
        run = 1'b0;
        run_until(700, 800);
        chk("norun_out_pulses", 32'(n_out), 32'd1);
        chk("norun_frame_count", 32'(frame_count), 32'd7);
        clr_trk();
        run_until(700, 4100);
        chk("norun_no_conv", 32'(n_conv), 32'd0);
        chk("norun_busy", 32'(busy), 32'd0);

        // Reset asserted during OUT_PULSE
        run = 1'b1;
        clr_trk();
        run_until(613, 4100);
        chk("rst_in_out_pulse", 32'(enable_out), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_outputs", 32'({enable_conv, enable_lag, enable_out, enable_sampling, enable_cancel,
                                      busy, timeout_err, overrun, frame_count}), 32'd0);
        step(); step();
        rst = 1'b0;
        clr_trk();
        run_until(3999, 4100);
        chk("post_rst_idle", 32'(n_conv), 32'd0);
        run_until(700, 800);
        chk("post_rst_conv_rise", 32'(conv_rise_c), 32'd1);
        chk("post_rst_frame_count", 32'(frame_count), 32'd1);
        chk("post_rst_flags", 32'({timeout_err, overrun}), 32'd0);

        chk("pulse_exclusive", 32'(excl_viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
